// File: rtl/siso_layer_scheduler.sv
// Read-side sequencer for the pipelined SISO row unit: issues one row per cycle per layer,
// then drains the row-unit pipeline before moving to the next layer or iteration.
module siso_layer_scheduler #(
  parameter int LAYERS    = 2,
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20,
  parameter int ITERBITS  = 5,
  parameter int OUTBITS   = 6,
  parameter int TIMEOUT   = 63,
  localparam int LW       = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 wb_wren,
  output logic [LW-1:0]        rdlayer_regin,
  output logic [ADDRWIDTH-1:0] rdaddress_regin,
  output logic                 rden_LLR_regin,
  output logic                 rden_E,
  output logic                 busy,
  output logic                 done,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0]        LAST_LAYER  = LW'(LAYERS - 1);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR   = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [TW-1:0]        DRAIN_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        layer_q, layer_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [ITERBITS-1:0]  iter_q, iter_d;
  logic [ITERBITS-1:0]  max_iter_q, max_iter_d;
  logic [OUTBITS-1:0]   inflight_q, inflight_d;
  logic [TW-1:0]        drain_q, drain_d;
  logic                 rden_llr_q, rden_llr_d;
  logic                 rden_e_q, rden_e_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [ITERBITS:0]    next_iter_s;

  assign next_iter_s = {1'b0, iter_q} + (ITERBITS + 1)'(1);

  // Next-state logic for the FSM, the in-flight row counter and all registered outputs.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    addr_d     = addr_q;
    iter_d     = iter_q;
    max_iter_d = max_iter_q;
    drain_d    = drain_q;
    rden_llr_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    inflight_d = inflight_q;
    // E-memory read lines up with the row unit's own registered copy of the address
    rden_e_d   = rden_llr_q && (iter_q != '0);

    if (rden_llr_q && !wb_wren) begin
      inflight_d = inflight_q + OUTBITS'(1);
    end else if (!rden_llr_q && wb_wren) begin
      if (inflight_q == '0) begin
        err_d = 1'b1;
      end else begin
        inflight_d = inflight_q - OUTBITS'(1);
      end
    end else begin
      inflight_d = inflight_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          max_iter_d = max_iter;
          layer_d    = '0;
          addr_d     = '0;
          iter_d     = '0;
          err_d      = 1'b0;
          inflight_d = '0;
          drain_d    = '0;
          busy_d     = 1'b1;
          if (max_iter == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ISSUE;
            rden_llr_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_d     = addr_q + ADDRWIDTH'(1);
          rden_llr_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0) begin
          drain_d = '0;
          if (layer_q != LAST_LAYER) begin
            layer_d    = layer_q + LW'(1);
            addr_d     = '0;
            rden_llr_d = 1'b1;
            state_d    = S_ISSUE;
          end else if (next_iter_s < {1'b0, max_iter_q}) begin
            iter_d     = next_iter_s[ITERBITS-1:0];
            layer_d    = '0;
            addr_d     = '0;
            rden_llr_d = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else if (drain_q == DRAIN_LIMIT) begin
          // a row never came back: flag it and give up on this decode
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          drain_d = drain_q + TW'(1);
        end
      end
      S_DONE: begin
        // zero-iteration decodes arrive here with done low and spend one busy cycle first
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      layer_q    <= '0;
      addr_q     <= '0;
      iter_q     <= '0;
      max_iter_q <= '0;
      inflight_q <= '0;
      drain_q    <= '0;
      rden_llr_q <= 1'b0;
      rden_e_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      addr_q     <= addr_d;
      iter_q     <= iter_d;
      max_iter_q <= max_iter_d;
      inflight_q <= inflight_d;
      drain_q    <= drain_d;
      rden_llr_q <= rden_llr_d;
      rden_e_q   <= rden_e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rdlayer_regin   = layer_q;
  assign rdaddress_regin = addr_q;
  assign rden_LLR_regin  = rden_llr_q;
  assign rden_E          = rden_e_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign iter_count      = iter_q;
  assign err             = err_q;

endmodule
